// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX path (and the future RX path).
package uart_pkg;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_tx_state_t;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by its single consumer (master) and by the FIFO (slave).
interface fifo_uart_tx_if;
  import uart_pkg::*;
  logic                      fifo_rden;
  logic                      fifo_empty;
  logic                      fifo_read_valid;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  modport master (output fifo_rden, input fifo_empty, fifo_dout, fifo_read_valid);
  modport slave  (input fifo_rden, output fifo_empty, fifo_dout, fifo_read_valid);
endinterface

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter; tick marks the last cycle of each period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // tick must not depend on clr: the owner derives clr from tick.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and sends each as an 8N1 UART frame.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int WAIT_MAX     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  read_err
);
  localparam int            BW        = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);
  localparam int            WW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  uart_tx_state_t            state, state_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic [BW-1:0]             bit_idx, bit_idx_nxt;
  logic [WW-1:0]             wait_cnt, wait_cnt_nxt;
  logic                      tx_nxt, err_nxt, tick, clr;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .tick    (tick)
  );

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_idx_nxt  = bit_idx;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = 1'b0;
    tx_done      = 1'b0;
    case (state)
      ST_IDLE:  if (en && !fifo.fifo_empty) state_nxt = ST_REQ;
      ST_REQ: begin
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = '0;
      end
      ST_WAIT: begin
        if (fifo.fifo_read_valid) begin
          state_nxt = ST_START;
          shreg_nxt = fifo.fifo_dout;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ST_START: if (tick) begin
        state_nxt   = ST_DATA;
        bit_idx_nxt = '0;
      end
      ST_DATA: if (tick) begin
        shreg_nxt = shreg >> 1;
        if (bit_idx == LAST_BIT) state_nxt = ST_STOP;
        else                     bit_idx_nxt = bit_idx + 1'b1;
      end
      ST_STOP: if (tick) begin
        state_nxt = ST_IDLE;
        tx_done   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Bit-period counter restarts on every state entry.
    clr = (state_nxt != state);

    // Line level is computed from the next state so tx itself is a flop.
    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shreg_nxt[0];
      default:  tx_nxt = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      shreg          <= '0;
      bit_idx        <= '0;
      wait_cnt       <= '0;
      tx             <= UART_IDLE_LEVEL;
      fifo.fifo_rden <= 1'b0;
      read_err       <= 1'b0;
    end else begin
      state          <= state_nxt;
      shreg          <= shreg_nxt;
      bit_idx        <= bit_idx_nxt;
      wait_cnt       <= wait_cnt_nxt;
      tx             <= tx_nxt;
      fifo.fifo_rden <= (state_nxt == ST_REQ);
      read_err       <= err_nxt;
    end
  end

  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx against a FIFO model and a frame-level line model.
module tb_fifo_uart_tx;
  localparam int CPB  = 4;
  localparam int WMAX = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic tx, busy, tx_done, read_err;

  fifo_uart_tx_if fif ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .WAIT_MAX(WMAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .fifo     (fif.master),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done),
    .read_err (read_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int n_rden = 0, n_done = 0, n_err = 0, n_busy = 0;
  logic [7:0] q[$];
  logic       suppress = 1'b0;
  logic       pend = 1'b0;
  logic [7:0] pend_b = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO with one-cycle read_valid latency, plus event counters.
  always @(negedge clk) begin
    fif.fifo_read_valid = pend && !suppress;
    fif.fifo_dout       = pend ? pend_b : 8'h00;
    pend = 1'b0;
    if (fif.fifo_rden === 1'b1 && q.size() > 0) begin
      pend_b = q.pop_front();
      pend   = 1'b1;
    end
    fif.fifo_empty = (q.size() == 0);
    if (fif.fifo_rden === 1'b1) n_rden++;
    if (tx_done === 1'b1)       n_done++;
    if (read_err === 1'b1)      n_err++;
    if (busy === 1'b1)          n_busy++;
  end

  task automatic wait_rden(output int k, output bit ok);
    ok = 1'b0;
    k  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fif.fifo_rden === 1'b1) begin
        ok = 1'b1;
        k  = cyc;
        break;
      end
    end
    if (!ok) chk("rden_timeout", 32'd0, 32'd1);
  endtask

  // Frame on the line is {stop, data LSB first, start}; sampled mid-bit.
  task automatic expect_frame(input logic [7:0] b, input int drop_at, output int k);
    bit ok;
    logic [9:0] fr;
    wait_rden(k, ok);
    if (!ok) return;
    fr = {1'b1, b, 1'b0};
    @(negedge clk); chk("tx_before_start", 32'(tx), 32'd1);
    @(negedge clk); chk("tx_fall_k2", 32'(tx), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat (CPB) @(negedge clk);
      if (i == drop_at) en = 1'b0;
      chk($sformatf("frame_%02h_bit%0d", b, i), 32'(tx), 32'(fr[i]));
    end
  endtask

  initial begin
    int k, k1, k2, b_rden, b_done, b_err, b_busy;
    bit ok, bad;
    logic [7:0] rb[6];

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rden", 32'(fif.fifo_rden), 32'd0);
    chk("rst_done_err", {30'd0, tx_done, read_err}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte
    b_rden = n_rden; b_done = n_done; b_busy = n_busy;
    q.push_back(8'hA5);
    en = 1'b1;
    expect_frame(8'hA5, -1, k);
    repeat (10) @(negedge clk);
    chk("single_rden_cnt", n_rden - b_rden, 1);
    chk("single_done_cnt", n_done - b_done, 1);
    chk("single_busy_cycles", n_busy - b_busy, 10 * CPB + 2);

    // back-to-back
    b_rden = n_rden; b_done = n_done;
    en = 1'b0;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    en = 1'b1;
    expect_frame(8'h00, -1, k1);
    expect_frame(8'hFF, -1, k2);
    chk("b2b_gap", k2 - k1, 10 * CPB + 3);
    repeat (20) @(negedge clk);
    chk("b2b_rden_cnt", n_rden - b_rden, 2);
    chk("b2b_done_cnt", n_done - b_done, 2);
    chk("b2b_empty", 32'(fif.fifo_empty), 32'd1);

    // en gating
    en = 1'b0;
    b_rden = n_rden;
    q.push_back(8'h3C);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || fif.fifo_rden !== 1'b0) bad = 1'b1;
    end
    chk("gate_idle_line", 32'(bad), 32'd0);
    chk("gate_rden_cnt", n_rden - b_rden, 0);
    en = 1'b1;
    expect_frame(8'h3C, -1, k);
    repeat (8) @(negedge clk);

    // en dropped during DATA with more bytes queued
    en = 1'b0;
    b_rden = n_rden;
    q.push_back(8'h5A); q.push_back(8'h11); q.push_back(8'h22);
    en = 1'b1;
    expect_frame(8'h5A, 3, k);
    repeat (30) @(negedge clk);
    chk("drop_rden_cnt", n_rden - b_rden, 1);
    chk("drop_left_in_fifo", q.size(), 2);
    q.delete();
    repeat (2) @(negedge clk);

    // missing read_valid
    suppress = 1'b1;
    b_err = n_err; b_done = n_done;
    q.push_back(8'h77);
    en = 1'b1;
    wait_rden(k, ok);
    if (ok) begin
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        chk($sformatf("noval_err_k%0d", j), 32'(read_err), (j == 1 + WMAX) ? 32'd1 : 32'd0);
        chk($sformatf("noval_tx_k%0d", j), 32'(tx), 32'd1);
        if (j == 1 + WMAX) chk("noval_idle", 32'(busy), 32'd0);
      end
    end
    repeat (5) @(negedge clk);
    chk("noval_err_cnt", n_err - b_err, 1);
    chk("noval_done_cnt", n_done - b_done, 0);
    suppress = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);

    // reset during bit 4 of 0x81
    q.push_back(8'h81); q.push_back(8'h42);
    en = 1'b1;
    wait_rden(k, ok);
    if (ok) begin
      repeat (24) @(negedge clk);
      chk("rst_mid_bit4", 32'(tx), 32'd0);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_mid_tx", 32'(tx), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_rden", 32'(fif.fifo_rden), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      expect_frame(8'h42, -1, k);
    end
    repeat (8) @(negedge clk);

    // random back-to-back burst
    en = 1'b0;
    b_rden = n_rden;
    foreach (rb[i]) begin
      rb[i] = 8'($urandom_range(0, 255));
      q.push_back(rb[i]);
    end
    repeat (2) @(negedge clk);
    en = 1'b1;
    foreach (rb[i]) begin
      expect_frame(rb[i], -1, k2);
      if (i > 0) chk($sformatf("rand_gap%0d", i), k2 - k1, 10 * CPB + 3);
      k1 = k2;
    end
    repeat (20) @(negedge clk);
    chk("rand_rden_cnt", n_rden - b_rden, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
